// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 3-stage pipeline flow controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_KILL = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;

  // Per-stage destination bookkeeping used for hazard and forwarding decisions.
  typedef struct packed {
    logic       valid;
    logic       wren;
    logic       is_load;
    logic [4:0] rd;
  } shadow_t;

  localparam shadow_t NOP_SHADOW = '0;

  // True when a stage's pending write targets a non-zero source register.
  function automatic logic reg_match(input logic       valid,
                                     input logic       wren,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return valid && wren && (rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the datapath (master) and the controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             id_wren_rf;
  logic             id_is_load;
  logic [4:0]       id_rd;
  logic             ex_redirect;

  logic             pc_en;
  logic             ex_en;
  logic             wb_en;
  logic             ex_bubble;
  logic             pc_sel_redirect;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             ex_valid;
  logic             wb_valid;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    output stall, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_wren_rf, id_is_load, id_rd, ex_redirect,
    input  pc_en, ex_en, wb_en, ex_bubble, pc_sel_redirect,
           fwd_a_sel, fwd_b_sel, ex_valid, wb_valid, cycle_cnt, instret_cnt
  );

  modport slave (
    input  stall, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_wren_rf, id_is_load, id_rd, ex_redirect,
    output pc_en, ex_en, wb_en, ex_bubble, pc_sel_redirect,
           fwd_a_sel, fwd_b_sel, ex_valid, wb_valid, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register; EX beats WB, loads in EX never forward.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  shadow_t    i_ex,
  input  logic       i_wb_valid,
  input  logic       i_wb_wren,
  input  logic [4:0] i_wb_rd,
  output logic [1:0] o_sel
);
  logic w_ex_hit;
  logic w_wb_hit;

  // Prioritised comparator against the EX and WB destination shadows.
  always_comb begin
    w_ex_hit = reg_match(i_ex.valid, i_ex.wren, i_ex.rd, i_rs) && !i_ex.is_load;
    w_wb_hit = reg_match(i_wb_valid, i_wb_wren, i_wb_rd, i_rs);
    o_sel    = FWD_RF;
    if (w_ex_hit) begin
      o_sel = FWD_EX;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Flow controller for the IF/ID, EX, WB pipeline: enables, bubbles, kills,
// forwarding selects and the cycle/instret counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit          LOAD_USE_STALL = 1'b1,
  parameter int unsigned KILL_SLOTS     = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam logic [1:0] KILL_INIT = 2'(KILL_SLOTS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_kill_cnt;
  logic [1:0]       w_kill_nxt;
  shadow_t          r_ex;
  shadow_t          w_id_shadow;
  logic             r_wb_valid;
  logic             r_wb_wren;
  logic [4:0]       r_wb_rd;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  logic             w_pc_en;
  logic             w_ex_en;
  logic             w_wb_en;
  logic             w_ex_bubble;
  logic             w_redirect;
  logic             w_redir_ok;
  logic             w_load_use;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Hazard detection against the instruction currently held in EX.
  always_comb begin
    w_redir_ok  = bus.ex_redirect && r_ex.valid;
    w_load_use  = LOAD_USE_STALL && r_ex.valid && r_ex.is_load && (r_ex.rd != 5'd0) &&
                  ((bus.id_uses_rs1 && (bus.id_rs1 == r_ex.rd)) ||
                   (bus.id_uses_rs2 && (bus.id_rs2 == r_ex.rd)));
    w_id_shadow = '{valid: 1'b1, wren: bus.id_wren_rf, is_load: bus.id_is_load, rd: bus.id_rd};
  end

  // Next-state and enable decode; stall freezes every state.
  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill_cnt;
    w_pc_en     = 1'b0;
    w_ex_en     = 1'b0;
    w_wb_en     = 1'b0;
    w_ex_bubble = 1'b0;
    w_redirect  = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_ex_bubble = 1'b1;
        if (!bus.stall) begin
          w_pc_en     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stall) begin
          w_ex_bubble = 1'b0;
        end else if (w_redir_ok) begin
          w_redirect  = 1'b1;
          w_pc_en     = 1'b1;
          w_ex_en     = 1'b1;
          w_wb_en     = 1'b1;
          w_ex_bubble = 1'b1;
          w_kill_nxt  = KILL_INIT;
          if (KILL_INIT != 2'd0) begin
            w_state_nxt = S_KILL;
          end
        end else if (w_load_use) begin
          w_ex_en     = 1'b1;
          w_wb_en     = 1'b1;
          w_ex_bubble = 1'b1;
        end else begin
          w_pc_en = 1'b1;
          w_ex_en = 1'b1;
          w_wb_en = 1'b1;
        end
      end
      S_KILL: begin
        w_ex_bubble = 1'b1;
        if (!bus.stall) begin
          w_pc_en    = 1'b1;
          w_ex_en    = 1'b1;
          w_wb_en    = 1'b1;
          w_kill_nxt = r_kill_cnt - 2'd1;
          if (r_kill_cnt == 2'd1) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // State and kill-slot counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_BOOT;
      r_kill_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_kill_cnt <= w_kill_nxt;
    end
  end

  // EX/WB destination shadows advance with their stage enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex       <= NOP_SHADOW;
      r_wb_valid <= 1'b0;
      r_wb_wren  <= 1'b0;
      r_wb_rd    <= '0;
    end else begin
      if (w_ex_en) begin
        r_ex <= w_ex_bubble ? NOP_SHADOW : w_id_shadow;
      end
      if (w_wb_en) begin
        r_wb_valid <= r_ex.valid;
        r_wb_wren  <= r_ex.wren;
        r_wb_rd    <= r_ex.rd;
      end
    end
  end

  // Free-running cycle counter and retirement counter (both wrap).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (r_wb_valid && w_wb_en) begin
        r_instret_cnt <= r_instret_cnt + CNT_W'(1);
      end
    end
  end

  fwd_unit u_fwd_a (
    .i_rs       (bus.id_rs1),
    .i_ex       (r_ex),
    .i_wb_valid (r_wb_valid),
    .i_wb_wren  (r_wb_wren),
    .i_wb_rd    (r_wb_rd),
    .o_sel      (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_rs       (bus.id_rs2),
    .i_ex       (r_ex),
    .i_wb_valid (r_wb_valid),
    .i_wb_wren  (r_wb_wren),
    .i_wb_rd    (r_wb_rd),
    .o_sel      (w_fwd_b)
  );

  // The state register idles in S_BOOT under reset, so enables are also gated by
  // reset to present the quiescent values while reset is held.
  assign bus.pc_en           = reset & w_pc_en;
  assign bus.ex_en           = reset & w_ex_en;
  assign bus.wb_en           = reset & w_wb_en;
  assign bus.ex_bubble       = ~reset | w_ex_bubble;
  assign bus.pc_sel_redirect = reset & w_redirect;
  assign bus.fwd_a_sel       = w_fwd_a;
  assign bus.fwd_b_sel       = w_fwd_b;
  assign bus.ex_valid        = r_ex.valid;
  assign bus.wb_valid        = r_wb_valid;
  assign bus.cycle_cnt       = r_cycle_cnt;
  assign bus.instret_cnt     = r_instret_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised scoreboard bench for pipe_hazard_ctrl with a slot-level pipeline model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned CW    = 32;
  localparam int unsigned KILLS = 2;

  logic clk;
  logic rst_n;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .LOAD_USE_STALL (1'b1),
    .KILL_SLOTS     (KILLS),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic v;
    logic wr;
    logic ld;
    logic [4:0] rd;
  } slot_t;

  typedef struct packed {
    logic pc_en;
    logic ex_en;
    logic wb_en;
    logic bub;
    logic bub_care;
    logic sel;
    logic [1:0] fa;
    logic [1:0] fb;
    logic ev;
    logic wv;
    logic [CW-1:0] cyc;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: instruction slots in EX and WB, boot flag, remaining wrong-path bubbles.
  slot_t       m_ex, m_wb;
  bit          m_boot;
  int unsigned m_kill_left;
  logic [CW-1:0] m_cyc, m_ret;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs != 5'd0 && m_ex.v && m_ex.wr && !m_ex.ld && m_ex.rd == rs) return 2'd1;
    if (rs != 5'd0 && m_wb.v && m_wb.wr && m_wb.rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_cycle();
    exp_t e;
    logic load_use;
    e = '0;
    if (!rst_n) begin
      m_ex = '0; m_wb = '0; m_boot = 1'b1; m_kill_left = 0; m_cyc = '0; m_ret = '0;
      e.bub = 1'b1; e.bub_care = 1'b1;
      q.push_back(e);
      return;
    end
    e.fa = exp_fwd(bus.id_rs1);
    e.fb = exp_fwd(bus.id_rs2);
    e.ev = m_ex.v; e.wv = m_wb.v; e.cyc = m_cyc; e.ret = m_ret;
    e.bub_care = !bus.stall;
    load_use = m_ex.v && m_ex.ld && m_ex.rd != 5'd0 &&
               ((bus.id_uses_rs1 && bus.id_rs1 == m_ex.rd) || (bus.id_uses_rs2 && bus.id_rs2 == m_ex.rd));
    if (m_boot) begin
      e.bub = 1'b1;
      if (!bus.stall) begin
        e.pc_en = 1'b1;
        m_boot = 1'b0;
      end
    end else if (bus.stall) begin
      // everything frozen
    end else if (m_kill_left > 0) begin
      e.pc_en = 1; e.ex_en = 1; e.wb_en = 1; e.bub = 1;
      m_kill_left--;
    end else if (bus.ex_redirect && m_ex.v) begin
      e.pc_en = 1; e.ex_en = 1; e.wb_en = 1; e.bub = 1; e.sel = 1;
      m_kill_left = KILLS - 1;
    end else if (load_use) begin
      e.ex_en = 1; e.wb_en = 1; e.bub = 1;
    end else begin
      e.pc_en = 1; e.ex_en = 1; e.wb_en = 1;
    end
    q.push_back(e);
    if (e.wb_en) begin
      if (m_wb.v) m_ret = m_ret + 1;
      m_wb = m_ex;
    end
    if (e.ex_en) m_ex = e.bub ? slot_t'('0) : '{v: 1'b1, wr: bus.id_wren_rf, ld: bus.id_is_load, rd: bus.id_rd};
    m_cyc = m_cyc + 1;
  endtask

  task automatic step(input logic st, input logic rdr,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic ld);
    @(negedge clk);
    bus.stall = st; bus.ex_redirect = rdr;
    bus.id_rs1 = rs1; bus.id_uses_rs1 = u1;
    bus.id_rs2 = rs2; bus.id_uses_rs2 = u2;
    bus.id_rd = rd; bus.id_wren_rf = wr; bus.id_is_load = ld;
    model_cycle();
  endtask

  task automatic rst_step(input logic r);
    @(negedge clk);
    rst_n = r;
    model_cycle();
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: compares every pushed expectation against the settled DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_en", CW'(bus.pc_en), CW'(e.pc_en));
        chk("ex_en", CW'(bus.ex_en), CW'(e.ex_en));
        chk("wb_en", CW'(bus.wb_en), CW'(e.wb_en));
        chk("pc_sel_redirect", CW'(bus.pc_sel_redirect), CW'(e.sel));
        if (e.bub_care) chk("ex_bubble", CW'(bus.ex_bubble), CW'(e.bub));
        chk("fwd_a_sel", CW'(bus.fwd_a_sel), CW'(e.fa));
        chk("fwd_b_sel", CW'(bus.fwd_b_sel), CW'(e.fb));
        chk("ex_valid", CW'(bus.ex_valid), CW'(e.ev));
        chk("wb_valid", CW'(bus.wb_valid), CW'(e.wv));
        chk("cycle_cnt", bus.cycle_cnt, e.cyc);
        chk("instret_cnt", bus.instret_cnt, e.ret);
      end
    end
  end

  initial begin
    int unsigned guard;
    rst_n = 1'b0;
    bus.stall = 0; bus.ex_redirect = 0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.id_rd = '0; bus.id_wren_rf = 0; bus.id_is_load = 0;

    // reset held three cycles, then boot and first run cycle
    repeat (3) rst_step(1'b0);
    rst_step(1'b1);
    idle();

    // forwarding: add x5, consumer rs1=5, then rs2=5 from WB with rs1=0
    step(0, 0, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    step(0, 0, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    step(0, 0, 5'd0, 1, 5'd5, 1, 5'd8, 1, 0);

    // load-use: lw x7 then consumer of rs2=7 held in ID across the bubble
    step(0, 0, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
    step(0, 0, 5'd3, 1, 5'd7, 1, 5'd9, 1, 0);
    step(0, 0, 5'd3, 1, 5'd7, 1, 5'd9, 1, 0);
    idle();

    // taken branch in EX with two kill slots
    step(0, 0, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0);
    step(0, 1, 5'd3, 1, 5'd4, 1, 5'd10, 1, 0);
    step(0, 0, 5'd3, 1, 5'd4, 1, 5'd11, 1, 0);
    idle();
    idle();

    // redirect held pending across a 4-cycle stall
    step(0, 0, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0);
    repeat (4) step(1, 1, 5'd3, 1, 5'd4, 1, 5'd12, 1, 0);
    step(0, 1, 5'd3, 1, 5'd4, 1, 5'd12, 1, 0);
    idle();
    idle();

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    end
    repeat (2) idle();

    // reset asserted while the controller is squashing wrong-path slots
    step(0, 0, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    rst_step(1'b0);
    rst_step(1'b0);
    rst_step(1'b1);
    idle();
    idle();

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
